// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider for DIV/DIVU: one quotient bit per clock,
// fixed WIDTH+2 cycle latency from accept to the done pulse, including special cases.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Two's-complement negate when sel is set; also yields |MIN| as unsigned MIN.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic sel);
        return sel ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_mag_q, dvsr_mag_d;
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
    logic [WIDTH-1:0] dvs_raw_q, dvs_raw_d;
    logic             sgn_q, sgn_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dvs_q, neg_dvs_d;

    logic        [WIDTH:0] rem_shift;
    logic signed [WIDTH:0] trial;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_out_d  = quo_out_q;
        rem_out_d  = rem_out_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_mag_d = dvsr_mag_q;
        dvd_raw_d  = dvd_raw_q;
        dvs_raw_d  = dvs_raw_q;
        sgn_d      = sgn_q;
        neg_dvd_d  = neg_dvd_q;
        neg_dvs_d  = neg_dvs_q;

        // Shifted partial remainder and trial subtraction, both WIDTH+1 bits wide.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr_mag_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sgn_d      = is_signed;
                    neg_dvd_d  = is_signed & dividend[WIDTH-1];
                    neg_dvs_d  = is_signed & divisor[WIDTH-1];
                    dvd_raw_d  = dividend;
                    dvs_raw_d  = divisor;
                    quo_d      = cond_neg(dividend, is_signed & dividend[WIDTH-1]);
                    dvsr_mag_d = cond_neg(divisor, is_signed & divisor[WIDTH-1]);
                    rem_d      = '0;
                    cnt_d      = '0;
                    dz_d       = 1'b0;
                    ov_d       = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (dvs_raw_q == '0) begin
                    quo_out_d = '1;
                    rem_out_d = dvd_raw_q;
                    dz_d      = 1'b1;
                end else if (sgn_q && dvd_raw_q == MIN_VAL && dvs_raw_q == '1) begin
                    quo_out_d = dvd_raw_q;
                    rem_out_d = '0;
                    ov_d      = 1'b1;
                end else begin
                    quo_out_d = cond_neg(quo_q, neg_dvd_q ^ neg_dvs_q);
                    rem_out_d = cond_neg(rem_q, neg_dvd_q);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvsr_mag_q <= dvsr_mag_d;
        dvd_raw_q  <= dvd_raw_d;
        dvs_raw_q  <= dvs_raw_d;
        sgn_q      <= sgn_d;
        neg_dvd_q  <= neg_dvd_d;
        neg_dvs_q  <= neg_dvs_d;
    end

    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider (WIDTH=32) against an arithmetic
// reference model built on the language's own / and % operators.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division with the divide-by-zero and MIN/-1 conventions.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = a;
            r  = 32'd0;
            ov = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at the negedge of cycle +1 after the accept edge.
    task automatic wait_check(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        edz, eov;
        int          n;
        logic        busy_ok;
        model(s, a, b, eq, er, edz, eov);
        n = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd34);
        chk("busy_profile", {31'd0, busy_ok}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        chk("overflow", {31'd0, overflow}, {31'd0, eov});
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("quotient_held", quotient, eq);
    endtask

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        wait_check(s, a, b);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(1'b1, 32'd100, 32'd7);
        do_div(1'b1, -32'sd7, 32'd2);
        do_div(1'b1, 32'd7, -32'sd2);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd2);
        do_div(1'b1, 32'hFFFF_FFFF, 32'd2);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(1'b1, 32'h0000_1234, 32'd0);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(1'b1, 32'h8000_0000, 32'd1);

        // start held high: second operand set waits until the divider is idle again
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd9;
        @(negedge clk);
        dividend = 32'd77;
        divisor = 32'd5;
        wait_check(1'b0, 32'd1000, 32'd9);
        chk("held_start_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_check(1'b0, 32'd77, 32'd5);

        // reset in the middle of RUN discards the operation
        start = 1'b1;
        is_signed = 1'b1;
        dividend = 32'd12345;
        divisor = 32'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        do_div(1'b1, -32'sd12345, 32'd11);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(1, 15);
                1:       rb = -($urandom_range(1, 300));
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_div(rs, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
